// File: rtl/tx_sequencer_pkg.sv
// Shared types and constants for the UART transmit sequencer.
// Holds state encodings, frame geometry and the frame builder.
package tx_sequencer_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        SHIFT = 2'd2
    } state_e;

    localparam int unsigned FRAME_BITS = 11;
    localparam int unsigned BIT_CNT_W  = 4;
    localparam logic        IDLE_LEVEL = 1'b1;

    // Assemble the LSB-first frame: start, data, optional parity, stop bits.
    function automatic logic [FRAME_BITS-1:0] build_frame(
        input logic [7:0] d,
        input logic       eight,
        input logic       pen,
        input logic       ohel
    );
        logic [7:0] data;
        logic       par;
        logic       b8;
        logic       b9;
        data = eight ? d : {1'b0, d[6:0]};
        par  = ohel ? ~^data : ^data;
        b8   = eight ? d[7] : (pen ? par : IDLE_LEVEL);
        b9   = eight ? (pen ? par : IDLE_LEVEL) : IDLE_LEVEL;
        return {IDLE_LEVEL, b9, b8, d[6:0], 1'b0};
    endfunction

endpackage

// File: rtl/tx_sequencer_bit_time_gen.sv
// Bit-time generator: counts 0..k-1 while enabled and flags the last clock of each bit.
// en is the next-cycle enable so btu can be registered and still align with the count.
module bit_time_gen #(
    parameter int unsigned BAUD_W = 20
) (
    input  logic              Clk,
    input  logic              Rst,
    input  logic              en,
    input  logic [BAUD_W-1:0] k,
    output logic              btu
);

    logic [BAUD_W-1:0] cnt_q;
    logic [BAUD_W-1:0] cnt_d;
    logic [BAUD_W-1:0] k_last;
    logic              run_q;

    // A divisor of 0 behaves as 1: every clock is a bit-time-up.
    assign k_last = (k == '0) ? '0 : k - BAUD_W'(1);

    always_comb begin
        cnt_d = '0;
        if (run_q && !btu) begin
            cnt_d = cnt_q + BAUD_W'(1);
        end
    end

    always_ff @(posedge Clk) begin
        if (!Rst || !en) begin
            cnt_q <= '0;
            run_q <= 1'b0;
            btu   <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            run_q <= 1'b1;
            btu   <= (cnt_d == k_last);
        end
    end

endmodule

// File: rtl/tx_sequencer.sv
// UART transmit sequencer: latches a byte, frames it and shifts it out at the baud rate.
// Optional TX_HOLD_EN adds a one-byte holding register for back-to-back frames.
module tx_sequencer
    import tx_sequencer_pkg::*;
#(
    parameter int unsigned BAUD_W = 20
) (
    input  logic              Clk,
    input  logic              Rst,
    input  logic              load,
    input  logic [7:0]        din,
    input  logic              eight,
    input  logic              pen,
    input  logic              ohel,
    input  logic [BAUD_W-1:0] baud_k,
    output logic              tx,
    output logic              txrdy,
    output logic              busy,
    output logic              btu
);

    state_e                  state_q;
    state_e                  state_d;
    logic [FRAME_BITS-1:0]   shift_q;
    logic [BIT_CNT_W-1:0]    bitcnt_q;
    logic                    txrdy_q;
    logic                    busy_q;
    logic                    txrdy_d;
    logic                    busy_d;
    logic [7:0]              lat_din_q;
    logic                    lat_eight_q;
    logic                    lat_pen_q;
    logic                    lat_ohel_q;
    logic [BAUD_W-1:0]       lat_k_q;
    logic                    take_load;
    logic                    latch_cfg;
    logic [7:0]              latch_din;
    logic                    done;
    logic                    bt_en;
`ifdef TX_HOLD_EN
    logic                    take_hold;
    logic                    hold_wr;
    logic                    hold_full_q;
    logic                    hold_full_d;
    logic [7:0]              hold_q;
`endif

    assign tx    = shift_q[0];
    assign txrdy = txrdy_q;
    assign busy  = busy_q;
    assign done  = (state_q == SHIFT) && btu && (bitcnt_q == BIT_CNT_W'(FRAME_BITS - 1));
    assign bt_en = (state_d == SHIFT);

    always_ff @(posedge Clk) begin
        if (!Rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        take_load = 1'b0;
        txrdy_d   = txrdy_q;
        busy_d    = busy_q;
        latch_cfg = 1'b0;
        latch_din = din;
`ifdef TX_HOLD_EN
        take_hold   = 1'b0;
        hold_wr     = 1'b0;
        hold_full_d = hold_full_q;
`endif
        case (state_q)
            IDLE: begin
`ifdef TX_HOLD_EN
                if (hold_full_q) begin
                    state_d   = LOAD;
                    take_hold = 1'b1;
                end else if (load) begin
                    state_d   = LOAD;
                    take_load = 1'b1;
                end
`else
                if (load) begin
                    state_d   = LOAD;
                    take_load = 1'b1;
                end
`endif
            end
            LOAD: state_d = SHIFT;
            SHIFT: begin
                if (done) begin
`ifdef TX_HOLD_EN
                    if (hold_full_q) begin
                        state_d   = LOAD;
                        take_hold = 1'b1;
                    end else begin
                        state_d = IDLE;
                    end
`else
                    state_d = IDLE;
`endif
                end
            end
            default: state_d = IDLE;
        endcase
`ifdef TX_HOLD_EN
        hold_wr     = load && !hold_full_q && !take_load;
        hold_full_d = (hold_full_q && !take_hold) || hold_wr;
        txrdy_d     = !hold_full_d;
        latch_cfg   = take_load || take_hold;
        latch_din   = take_hold ? hold_q : din;
`else
        txrdy_d     = (state_d == IDLE);
        latch_cfg   = take_load;
`endif
        busy_d = (state_d != IDLE);
    end

    // Framing datapath: configuration latch, shift register and bit counter.
    always_ff @(posedge Clk) begin
        if (!Rst) begin
            shift_q     <= {FRAME_BITS{IDLE_LEVEL}};
            bitcnt_q    <= '0;
            txrdy_q     <= 1'b1;
            busy_q      <= 1'b0;
            lat_din_q   <= '0;
            lat_eight_q <= 1'b0;
            lat_pen_q   <= 1'b0;
            lat_ohel_q  <= 1'b0;
            lat_k_q     <= '0;
        end else begin
            txrdy_q <= txrdy_d;
            busy_q  <= busy_d;
            if (latch_cfg) begin
                lat_din_q   <= latch_din;
                lat_eight_q <= eight;
                lat_pen_q   <= pen;
                lat_ohel_q  <= ohel;
                lat_k_q     <= baud_k;
            end
            if (state_q == LOAD) begin
                shift_q  <= build_frame(lat_din_q, lat_eight_q, lat_pen_q, lat_ohel_q);
                bitcnt_q <= '0;
            end else if ((state_q == SHIFT) && btu) begin
                shift_q  <= {IDLE_LEVEL, shift_q[FRAME_BITS-1:1]};
                bitcnt_q <= done ? '0 : bitcnt_q + BIT_CNT_W'(1);
            end
        end
    end

`ifdef TX_HOLD_EN
    always_ff @(posedge Clk) begin
        if (!Rst) begin
            hold_full_q <= 1'b0;
            hold_q      <= '0;
        end else begin
            hold_full_q <= hold_full_d;
            if (hold_wr) begin
                hold_q <= din;
            end
        end
    end
`endif

    bit_time_gen #(
        .BAUD_W (BAUD_W)
    ) u_bit_time_gen (
        .Clk (Clk),
        .Rst (Rst),
        .en  (bt_en),
        .k   (lat_k_q),
        .btu (btu)
    );

endmodule
